// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: SCL timing generator for the I2C master.
// Produces the open-drain SCL drive level with a runtime-programmable half
// period, plus phase strobes for the byte/bit engine. The HIGH phase only
// progresses while the synchronised SCL line is actually high. This lets
// slave clock stretching and arbitration pause it. The divisor is latched
// at every phase boundary, so a phase in progress keeps its length.
// SYNC_STAGES must be at least 2.
module i2c_scl_gen #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_clk,
  input  logic [CNT_W-1:0] half_cnt,
  input  logic             scl_in,
  output logic             scl_o,
  output logic             sample_h,
  output logic             sample_l,
  output logic             mid_l,
  output logic             stretch
);

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  phase_t                 phase;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       lim;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic                   scl_s;
  logic [CNT_W-1:0]       lim_next;
  logic                   end_high;
  logic                   end_low;

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  // A programmed half period of 0 would give a zero-length phase, so it is treated as 1.
  assign lim_next = (half_cnt == '0) ? ONE : half_cnt;
  assign end_high = en_clk && (phase == PH_HIGH) && scl_s && (count == lim);
  assign end_low  = en_clk && (phase == PH_LOW) && (count == lim);

  // Bring the asynchronous pad level into the clock domain; idles high like a released bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
    end
  end

  // Phase sequencer: counts out each half period and latches the divisor at phase boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PH_HIGH;
      count <= '0;
      lim   <= ONE;
    end else if (!en_clk) begin
      phase <= PH_HIGH;
      count <= '0;
      lim   <= lim_next;
    end else if (phase == PH_LOW) begin
      if (count == lim) begin
        phase <= PH_HIGH;
        count <= '0;
        lim   <= lim_next;
      end else begin
        count <= count + ONE;
      end
    end else if (scl_s) begin
      if (count == lim) begin
        phase <= PH_LOW;
        count <= '0;
        lim   <= lim_next;
      end else begin
        count <= count + ONE;
      end
    end
  end

  // Strobes decode registered state only, gated by en_clk so that idle is always silent
  always_comb begin
    scl_o    = en_clk ? (phase == PH_HIGH) : 1'b1;
    sample_h = end_high;
    sample_l = end_low;
    mid_l    = en_clk && (phase == PH_LOW) && (count == (lim >> 1));
    stretch  = en_clk && (phase == PH_HIGH) && !scl_s;
  end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// tb_i2c_scl_gen: directed bench for i2c_scl_gen.
// A timeline model derives the expected outputs on every cycle from phase start
// times and stall counts. Literal strobe cycle lists pin the model to the
// documented timing.
module tb_i2c_scl_gen;

  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en_clk = 1'b0;
  logic [CNT_W-1:0] half_cnt = 8'd5;
  logic             scl_drv = 1'b1;
  logic             loopback = 1'b0;
  logic             slave_rel = 1'b1;
  logic             scl_in;
  logic             scl_o, sample_h, sample_l, mid_l, stretch;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  // model state: a phase is described by its start cycle, stalled cycles and limit
  bit m_high = 1'b1;
  int m_lim = 1;
  int m_start = 1;
  int m_stalls = 0;
  bit syncq[$];

  // observed strobe cycles, relative to the current run start t0
  int qh[$];
  int qml[$];
  int qsl[$];
  int st_cnt = 0;

  // pad model: with loopback the line is the wired-AND of our drive and the slave
  assign scl_in = loopback ? (scl_o & slave_rel) : scl_drv;

  i2c_scl_gen #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_clk   (en_clk),
    .half_cnt (half_cnt),
    .scl_in   (scl_in),
    .scl_o    (scl_o),
    .sample_h (sample_h),
    .sample_l (sample_l),
    .mid_l    (mid_l),
    .stretch  (stretch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d (run cycle %0d): got %b expected %b",
               name, cyc, cyc - t0, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int getAt(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // per-cycle compare against the timeline model, then advance the model
  always @(negedge clk) begin
    bit e_scl, e_sh, e_sl, e_ml, e_st, sy;
    int el, lnext;
    e_scl = 1'b1; e_sh = 1'b0; e_sl = 1'b0; e_ml = 1'b0; e_st = 1'b0;
    lnext = (half_cnt == 0) ? 1 : int'(half_cnt);
    if (!rst_n) begin
      m_high = 1'b1; m_lim = 1; m_start = cyc + 1; m_stalls = 0;
      syncq.delete();
      repeat (SYNC_STAGES) syncq.push_back(1'b1);
    end else begin
      sy = syncq[0];
      el = cyc - m_start - m_stalls;
      if (!en_clk) begin
        m_high = 1'b1; m_start = cyc + 1; m_stalls = 0; m_lim = lnext;
      end else if (m_high) begin
        if (!sy) begin
          e_st = 1'b1;
          m_stalls++;
        end else if (el == m_lim) begin
          e_sh = 1'b1;
          m_high = 1'b0; m_start = cyc + 1; m_stalls = 0; m_lim = lnext;
        end
      end else begin
        e_scl = 1'b0;
        if (el == m_lim / 2) e_ml = 1'b1;
        if (el == m_lim) begin
          e_sl = 1'b1;
          m_high = 1'b1; m_start = cyc + 1; m_stalls = 0; m_lim = lnext;
        end
      end
      syncq.push_back(scl_in);
      void'(syncq.pop_front());
      if (sample_h === 1'b1) qh.push_back(cyc - t0);
      if (mid_l === 1'b1) qml.push_back(cyc - t0);
      if (sample_l === 1'b1) qsl.push_back(cyc - t0);
      if (stretch === 1'b1) st_cnt++;
    end
    checkOutput("scl_o", scl_o, e_scl);
    checkOutput("sample_h", sample_h, e_sh);
    checkOutput("sample_l", sample_l, e_sl);
    checkOutput("mid_l", mid_l, e_ml);
    checkOutput("stretch", stretch, e_st);
  end

  // hold idle for n cycles with the given divisor so it gets latched
  task automatic applyStimulus(input int half, input int n);
    @(posedge clk); #1;
    en_clk = 1'b0;
    half_cnt = CNT_W'(half);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // raise en_clk at the start of a cycle; that cycle becomes run cycle 0
  task automatic startRun();
    en_clk = 1'b1;
    t0 = cyc;
    qh.delete(); qml.delete(); qsl.delete();
    st_cnt = 0;
  endtask

  task automatic waitTo(input int k);
    while (cyc - t0 < k) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // reset state
    #2;
    checkOutput("reset scl_o", scl_o, 1'b1);
    checkOutput("reset sample_h", sample_h, 1'b0);
    checkOutput("reset stretch", stretch, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // basic divide by 12
    applyStimulus(5, 3);
    startRun();
    waitTo(36);
    checkValue("basic sample_h #0", getAt(qh, 0), 5);
    checkValue("basic sample_h #1", getAt(qh, 1), 17);
    checkValue("basic sample_h #2", getAt(qh, 2), 29);
    checkValue("basic mid_l #0", getAt(qml, 0), 8);
    checkValue("basic mid_l #1", getAt(qml, 1), 20);
    checkValue("basic sample_l #0", getAt(qsl, 0), 11);
    checkValue("basic sample_l #1", getAt(qsl, 1), 23);
    checkValue("basic stretch count", st_cnt, 0);

    // zero divisor behaves as 1
    applyStimulus(0, 3);
    startRun();
    waitTo(12);
    checkValue("min sample_h #0", getAt(qh, 0), 1);
    checkValue("min mid_l #0", getAt(qml, 0), 2);
    checkValue("min sample_l #0", getAt(qsl, 0), 3);
    checkValue("min sample_h #1", getAt(qh, 1), 5);
    checkValue("min sample_l #2", getAt(qsl, 2), 11);

    // slave stretch with looped-back pad
    applyStimulus(5, 3);
    loopback = 1'b1;
    slave_rel = 1'b1;
    startRun();
    waitTo(12);
    slave_rel = 1'b0;
    waitTo(22);
    slave_rel = 1'b1;
    waitTo(30);
    checkValue("stretch cycles", st_cnt, 12);
    waitTo(40);
    checkValue("stretch sample_h #0", getAt(qh, 0), 5);
    checkValue("stretch sample_h #1", getAt(qh, 1), 29);
    checkValue("stretch mid_l #1", getAt(qml, 1), 32);
    checkValue("stretch sample_l #1", getAt(qsl, 1), 35);

    // divisor change mid-HIGH only affects the next phase
    applyStimulus(5, 3);
    loopback = 1'b0;
    startRun();
    waitTo(3);
    half_cnt = 8'd9;
    waitTo(20);
    checkValue("divchg sample_h #0", getAt(qh, 0), 5);
    checkValue("divchg mid_l #0", getAt(qml, 0), 10);
    checkValue("divchg sample_l #0", getAt(qsl, 0), 15);

    // disable mid-LOW, then re-enable
    applyStimulus(5, 3);
    startRun();
    waitTo(8);
    en_clk = 1'b0;
    waitTo(12);
    checkValue("disable sample_h count", qh.size(), 1);
    checkValue("disable mid_l count", qml.size(), 0);
    checkValue("disable sample_l count", qsl.size(), 0);
    startRun();
    waitTo(8);
    checkValue("reenable sample_h #0", getAt(qh, 0), 5);

    // asynchronous reset while LOW
    applyStimulus(9, 3);
    startRun();
    waitTo(14);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async reset scl_o", scl_o, 1'b1);
    checkOutput("async reset sample_l", sample_l, 1'b0);
    checkOutput("async reset mid_l", mid_l, 1'b0);
    en_clk = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    startRun();
    waitTo(12);
    checkValue("post-reset sample_h #0", getAt(qh, 0), 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
